// File: rtl/led_trig_gen.sv
// led_trig_gen: NUM_CH independent, run-time configurable blink/trigger channels.
// Each channel runs a half-period counter. The counter's wrap events drive a
// square-wave LED, a strobe, or a single-shot pulse. Every output is registered.
module led_trig_gen #(
    parameter int          NUM_CH   = 4,
    parameter int          CNT_W    = 32,
    parameter int unsigned DEF_HALF = 32'd16777216,
    parameter int          DEF_MODE = 1,
    localparam int         CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              fpga_clk_in,
    input  logic              fpga_rst,
    input  logic              cfg_wr,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [1:0]        cfg_mode,
    input  logic [CNT_W-1:0]  cfg_half,
    input  logic              sync_clr,
    output logic              cfg_ack,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] led_out,
    output logic [NUM_CH-1:0] exti_trig
);

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_SQUARE  = 2'd1,
        MODE_STROBE  = 2'd2,
        MODE_ONESHOT = 2'd3
    } mode_e;

    localparam mode_e            RST_MODE = mode_e'(2'(DEF_MODE));
    localparam logic [CNT_W-1:0] RST_HALF = CNT_W'(DEF_HALF);

    // An index past the last channel is rejected. This only matters when
    // NUM_CH is not a power of two.
    logic ch_valid;
    assign ch_valid = ({1'b0, cfg_ch} < (CH_W + 1)'(NUM_CH));

    logic ack_q, ack_d;
    logic err_q, err_d;

    // Accept or reject a write; the result appears one cycle later.
    always_comb begin
        ack_d = cfg_wr && ch_valid;
        err_d = cfg_wr && !ch_valid;
    end

    // Register the acknowledge and error pulses. Reset drops a pending pulse.
    always_ff @(posedge fpga_clk_in) begin
        if (fpga_rst) begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            ack_q <= ack_d;
            err_q <= err_d;
        end
    end

    assign cfg_ack = ack_q;
    assign cfg_err = err_q;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            mode_e            mode_q, mode_d;
            logic [CNT_W-1:0] half_q, half_d;
            logic [CNT_W-1:0] cnt_q, cnt_d;
            logic             level_q, level_d;
            logic             led_q, led_d;
            logic             trig_q, trig_d;
            logic             wr_hit;
            logic [CNT_W-1:0] last_cnt;
            logic             wrap;

            assign wr_hit = cfg_wr && (cfg_ch == CH_W'(gi));
            // A half-period of 0 behaves like 1: the counter wraps on every edge.
            assign last_cnt = (half_q == '0) ? '0 : (half_q - CNT_W'(1));
            assign wrap     = (cnt_q == last_cnt);

            // Next state of the channel. Priority order: config write, then sync
            // clear, then normal counting. Pulses default to low.
            always_comb begin
                mode_d  = mode_q;
                half_d  = half_q;
                cnt_d   = cnt_q;
                level_d = level_q;
                led_d   = 1'b0;
                trig_d  = 1'b0;
                if (wr_hit) begin
                    // The write restarts the phase and takes priority over a
                    // wrap on this same edge, so no pulse is emitted.
                    mode_d  = mode_e'(cfg_mode);
                    half_d  = cfg_half;
                    cnt_d   = '0;
                    level_d = 1'b0;
                end else if (sync_clr) begin
                    cnt_d   = '0;
                    level_d = 1'b0;
                end else begin
                    unique case (mode_q)
                        MODE_OFF: begin
                            cnt_d   = '0;
                            level_d = 1'b0;
                        end
                        MODE_SQUARE: begin
                            if (wrap) begin
                                cnt_d   = '0;
                                level_d = ~level_q;
                                trig_d  = ~level_q;
                            end else begin
                                cnt_d = cnt_q + CNT_W'(1);
                            end
                            led_d = level_d;
                        end
                        MODE_STROBE: begin
                            level_d = 1'b0;
                            if (wrap) begin
                                cnt_d  = '0;
                                led_d  = 1'b1;
                                trig_d = 1'b1;
                            end else begin
                                cnt_d = cnt_q + CNT_W'(1);
                            end
                        end
                        MODE_ONESHOT: begin
                            level_d = 1'b0;
                            if (wrap) begin
                                cnt_d  = '0;
                                led_d  = 1'b1;
                                trig_d = 1'b1;
                                mode_d = MODE_OFF;
                            end else begin
                                cnt_d = cnt_q + CNT_W'(1);
                            end
                        end
                        default: begin
                            cnt_d   = '0;
                            level_d = 1'b0;
                        end
                    endcase
                end
            end

            // Channel state register. Reset restores the default mode and rate.
            always_ff @(posedge fpga_clk_in) begin
                if (fpga_rst) begin
                    mode_q  <= RST_MODE;
                    half_q  <= RST_HALF;
                    cnt_q   <= '0;
                    level_q <= 1'b0;
                    led_q   <= 1'b0;
                    trig_q  <= 1'b0;
                end else begin
                    mode_q  <= mode_d;
                    half_q  <= half_d;
                    cnt_q   <= cnt_d;
                    level_q <= level_d;
                    led_q   <= led_d;
                    trig_q  <= trig_d;
                end
            end

            assign led_out[gi]   = led_q;
            assign exti_trig[gi] = trig_q;
        end
    endgenerate

endmodule

// File: tb/tb_led_trig_gen.sv
// Bench for led_trig_gen. A four-channel instance is compared against a
// reference model. The model derives each channel's outputs from the number of
// edges since the channel last restarted: a wrap happens when that count is a
// multiple of the half-period. A three-channel instance shares the same
// stimulus, so a write to index 3 is an out-of-range write for that instance.
module tb_led_trig_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_wr;
    logic [1:0]  cfg_ch;
    logic [1:0]  cfg_mode;
    logic [31:0] cfg_half;
    logic        sync;
    logic        cfg_ack, cfg_err;
    logic [3:0]  led_out, exti_trig;
    logic        ack3, err3;
    logic [2:0]  led3, trig3;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    int      m_mode [4];
    longint  m_half [4];
    longint  m_age  [4];
    logic [3:0] m_led, m_trig;
    logic    m_ack, m_ack3, m_err3;

    always #5 clk = ~clk;

    led_trig_gen #(.NUM_CH(4), .CNT_W(32), .DEF_HALF(4), .DEF_MODE(1)) dut (
        .fpga_clk_in(clk), .fpga_rst(rst), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch),
        .cfg_mode(cfg_mode), .cfg_half(cfg_half), .sync_clr(sync),
        .cfg_ack(cfg_ack), .cfg_err(cfg_err), .led_out(led_out), .exti_trig(exti_trig)
    );

    led_trig_gen #(.NUM_CH(3), .CNT_W(32), .DEF_HALF(4), .DEF_MODE(1)) dut3 (
        .fpga_clk_in(clk), .fpga_rst(rst), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch),
        .cfg_mode(cfg_mode), .cfg_half(cfg_half), .sync_clr(sync),
        .cfg_ack(ack3), .cfg_err(err3), .led_out(led3), .exti_trig(trig3)
    );

    task automatic model_edge();
        longint h;
        longint n;
        logic   wrapev;
        m_led  = '0;
        m_trig = '0;
        m_ack  = 1'b0;
        m_ack3 = 1'b0;
        m_err3 = 1'b0;
        if (rst) begin
            for (int c = 0; c < 4; c++) begin
                m_mode[c] = 1;
                m_half[c] = 4;
                m_age[c]  = 0;
            end
        end else begin
            m_ack  = cfg_wr;
            m_ack3 = cfg_wr && (int'(cfg_ch) < 3);
            m_err3 = cfg_wr && (int'(cfg_ch) >= 3);
            for (int c = 0; c < 4; c++) begin
                if (cfg_wr && int'(cfg_ch) == c) begin
                    m_mode[c] = int'(cfg_mode);
                    m_half[c] = longint'(cfg_half);
                    m_age[c]  = 0;
                end else if (sync) begin
                    m_age[c] = 0;
                end else if (m_mode[c] != 0) begin
                    h = (m_half[c] == 0) ? 1 : m_half[c];
                    m_age[c]++;
                    wrapev = (m_age[c] % h) == 0;
                    n = m_age[c] / h;
                    case (m_mode[c])
                        1: begin
                            m_led[c]  = n[0];
                            m_trig[c] = wrapev && n[0];
                        end
                        2: begin
                            m_led[c]  = wrapev;
                            m_trig[c] = wrapev;
                        end
                        default: begin
                            m_led[c]  = wrapev;
                            m_trig[c] = wrapev;
                            if (wrapev) m_mode[c] = 0;
                        end
                    endcase
                end
            end
        end
    endtask

    // Advance one clock edge with the current inputs, update the model, and
    // return at the falling edge, where outputs are stable for sampling.
    task automatic tick();
        if (cfg_wr)
            $display("txn wr ch=%0d mode=%0d half=%0d sync=%0b rst=%0b", cfg_ch, cfg_mode, cfg_half, sync, rst);
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rst      = 1'b0;
        cfg_wr   = 1'b0;
        cfg_ch   = 2'd0;
        cfg_mode = 2'd0;
        cfg_half = 32'd0;
        sync     = 1'b0;
    endtask

    task automatic set_wr(input int c, input int m, input int h);
        cfg_wr   = 1'b1;
        cfg_ch   = 2'(c);
        cfg_mode = 2'(m);
        cfg_half = 32'(h);
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if ({led_out, exti_trig, cfg_ack, cfg_err, led3, trig3, ack3, err3} !== 16'd0) begin
                miscompares++;
                $display("FAIL reset cyc=%0d got led=%b trig=%b ack=%b err=%b led3=%b trig3=%b ack3=%b err3=%b want all 0",
                         i, led_out, exti_trig, cfg_ack, cfg_err, led3, trig3, ack3, err3);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_timeline();
        for (int k = 1; k <= 52; k++) begin
            idle_inputs();
            case (k)
                10: set_wr(1, 2, 3);
                20: set_wr(2, 3, 5);
                30: begin sync = 1'b1; set_wr(3, 1, 2); end
                40: set_wr(2, 3, 5);
                42: set_wr(3, 2, 2);
                47: set_wr(3, 1, 0);
                default: ;
            endcase
            tick();
            vectors++;
            if ({led_out, exti_trig, cfg_ack, cfg_err} !== {m_led, m_trig, m_ack, 1'b0}) begin
                miscompares++;
                $display("FAIL timeline k=%0d got led=%b trig=%b ack=%b err=%b want led=%b trig=%b ack=%b err=0",
                         k, led_out, exti_trig, cfg_ack, cfg_err, m_led, m_trig, m_ack);
            end
            vectors++;
            if ({led3, trig3, ack3, err3} !== {m_led[2:0], m_trig[2:0], m_ack3, m_err3}) begin
                miscompares++;
                $display("FAIL timeline3 k=%0d got led=%b trig=%b ack=%b err=%b want led=%b trig=%b ack=%b err=%b",
                         k, led3, trig3, ack3, err3, m_led[2:0], m_trig[2:0], m_ack3, m_err3);
            end
            // Fixed checkpoints taken straight from the scenario timeline
            case (k)
                4, 34: begin
                    vectors++;
                    if ({led_out[0], exti_trig[0]} !== 2'b11) begin
                        miscompares++;
                        $display("FAIL ch0_rise k=%0d got led/trig=%b%b want 11", k, led_out[0], exti_trig[0]);
                    end
                end
                5: begin
                    vectors++;
                    if ({led_out[0], exti_trig[0]} !== 2'b10) begin
                        miscompares++;
                        $display("FAIL ch0_trig_len k=%0d got led/trig=%b%b want 10", k, led_out[0], exti_trig[0]);
                    end
                end
                8, 30: begin
                    vectors++;
                    if (led_out[0] !== 1'b0) begin
                        miscompares++;
                        $display("FAIL ch0_low k=%0d got %b want 0", k, led_out[0]);
                    end
                end
                10: begin
                    vectors++;
                    if (cfg_ack !== 1'b1) begin
                        miscompares++;
                        $display("FAIL ack k=%0d got %b want 1", k, cfg_ack);
                    end
                end
                13, 16, 19: begin
                    vectors++;
                    if ({led_out[1], exti_trig[1]} !== 2'b11) begin
                        miscompares++;
                        $display("FAIL strobe k=%0d got led/trig=%b%b want 11", k, led_out[1], exti_trig[1]);
                    end
                end
                14: begin
                    vectors++;
                    if ({led_out[1], exti_trig[1]} !== 2'b00) begin
                        miscompares++;
                        $display("FAIL strobe_gap k=%0d got led/trig=%b%b want 00", k, led_out[1], exti_trig[1]);
                    end
                end
                25, 45: begin
                    vectors++;
                    if ({led_out[2], exti_trig[2]} !== 2'b11) begin
                        miscompares++;
                        $display("FAIL oneshot k=%0d got led/trig=%b%b want 11", k, led_out[2], exti_trig[2]);
                    end
                end
                35: begin
                    vectors++;
                    if ({led_out[2], exti_trig[2]} !== 2'b00) begin
                        miscompares++;
                        $display("FAIL oneshot_off k=%0d got led/trig=%b%b want 00", k, led_out[2], exti_trig[2]);
                    end
                end
                42: begin
                    vectors++;
                    if ({ack3, err3, cfg_ack} !== 3'b011) begin
                        miscompares++;
                        $display("FAIL bad_index k=%0d got ack3=%b err3=%b ack=%b want 0 1 1", k, ack3, err3, cfg_ack);
                    end
                end
                48, 50: begin
                    vectors++;
                    if (led_out[3] !== 1'b1) begin
                        miscompares++;
                        $display("FAIL half0 k=%0d got %b want 1", k, led_out[3]);
                    end
                end
                49: begin
                    vectors++;
                    if (led_out[3] !== 1'b0) begin
                        miscompares++;
                        $display("FAIL half0 k=%0d got %b want 0", k, led_out[3]);
                    end
                end
                default: ;
            endcase
        end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 4; c++) begin
            idle_inputs();
            set_wr(c, 2, 2 + c);
            tick();
            vectors++;
            if ({cfg_ack, led_out, exti_trig} !== {1'b1, m_led, m_trig}) begin
                miscompares++;
                $display("FAIL back_to_back ch=%0d got ack=%b led=%b trig=%b want ack=1 led=%b trig=%b",
                         c, cfg_ack, led_out, exti_trig, m_led, m_trig);
            end
        end
        idle_inputs();
        for (int i = 0; i < 12; i++) begin
            tick();
            vectors++;
            if ({led_out, exti_trig, cfg_ack, cfg_err} !== {m_led, m_trig, m_ack, 1'b0}) begin
                miscompares++;
                $display("FAIL b2b_run i=%0d got led=%b trig=%b ack=%b err=%b want led=%b trig=%b ack=%b err=0",
                         i, led_out, exti_trig, cfg_ack, cfg_err, m_led, m_trig, m_ack);
            end
        end
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        set_wr(2, 3, 6);
        for (int i = 0; i < 12; i++) begin
            if (i == 1) idle_inputs();
            if (i == 3) begin rst = 1'b1; set_wr(1, 2, 2); end   // reset with a write on the same edge
            if (i == 4) begin idle_inputs(); set_wr(0, 3, 3); end
            if (i == 5) begin idle_inputs(); rst = 1'b1; end     // reset during the ack cycle
            if (i == 6) idle_inputs();
            tick();
            vectors++;
            if ({led_out, exti_trig, cfg_ack, cfg_err} !== {m_led, m_trig, m_ack, 1'b0}) begin
                miscompares++;
                $display("FAIL reset_mid i=%0d got led=%b trig=%b ack=%b err=%b want led=%b trig=%b ack=%b err=0",
                         i, led_out, exti_trig, cfg_ack, cfg_err, m_led, m_trig, m_ack);
            end
            if (i == 3 || i == 5) begin
                vectors++;
                if ({led_out, exti_trig, cfg_ack, ack3} !== 10'd0) begin
                    miscompares++;
                    $display("FAIL reset_override i=%0d got led=%b trig=%b ack=%b ack3=%b want all 0",
                             i, led_out, exti_trig, cfg_ack, ack3);
                end
            end
        end
        idle_inputs();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            idle_inputs();
            if ($urandom_range(0, 3) == 0) begin
                set_wr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 9)));
            end
            sync = ($urandom_range(0, 15) == 0);
            rst  = ($urandom_range(0, 63) == 0);
            tick();
            vectors++;
            if ({led_out, exti_trig, cfg_ack, cfg_err} !== {m_led, m_trig, m_ack, 1'b0}) begin
                miscompares++;
                $display("FAIL random i=%0d got led=%b trig=%b ack=%b err=%b want led=%b trig=%b ack=%b err=0",
                         i, led_out, exti_trig, cfg_ack, cfg_err, m_led, m_trig, m_ack);
            end
            vectors++;
            if ({led3, trig3, ack3, err3} !== {m_led[2:0], m_trig[2:0], m_ack3, m_err3}) begin
                miscompares++;
                $display("FAIL random3 i=%0d got led=%b trig=%b ack=%b err=%b want led=%b trig=%b ack=%b err=%b",
                         i, led3, trig3, ack3, err3, m_led[2:0], m_trig[2:0], m_ack3, m_err3);
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_timeline();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
